// File: rtl/five_button_pulse.sv
// five_button_pulse
//   Turns five raw mechanical push-button levels into clean one-cycle press
//   pulses. Each channel has its own two-flop synchronizer, a
//   stability-counter debouncer and a rising-edge detector. Channels do not
//   interact.
//
// Ports
//   clk         system clock; all state changes on its rising edge
//   rst_n       asynchronous, active-low reset; clears all state to 0
//   raw_button  [4:0] unsynchronized button levels (bit i = button i)
//   button      [4:0] registered press pulses, one cycle per debounced press
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive cycles the synchronized level must differ
//                    from the debounced state before that state flips (>= 1)
//   CNT_W            counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Build option
//   FIVE_BUTTON_ACTIVE_LOW_EN  when defined, a low raw level means pressed
//                              (pull-up wiring). Reset still means released.
module five_button_pulse #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] raw_button,
   output logic [4:0] button
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [4:0]       s1_q, s1_d;
   logic [4:0]       s2_q, s2_d;
   logic [4:0]       stable_q, stable_d;
   logic [4:0]       button_q, button_d;
   logic [CNT_W-1:0] cnt_q [5];
   logic [CNT_W-1:0] cnt_d [5];

   // Internal polarity is always "1 = pressed"; inversion happens before the
   // first synchronizer flop so nothing downstream depends on the build.
`ifdef FIVE_BUTTON_ACTIVE_LOW_EN
   assign s1_d = ~raw_button;
`else
   assign s1_d = raw_button;
`endif
   assign s2_d = s1_q;

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 5; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s2_q[i] == stable_q[i]) begin
            // Any return to the debounced level restarts the count.
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CntLast) begin
            stable_d[i] = s2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
      // Pulse only on a debounced 0->1; releases are silent.
      button_d = stable_d & ~stable_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q     <= '0;
         s2_q     <= '0;
         stable_q <= '0;
         button_q <= '0;
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         button_q <= button_d;
         for (int i = 0; i < 5; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign button = button_q;

endmodule

// File: tb/tb_five_button_pulse.sv
// Self-checking bench for five_button_pulse with DEBOUNCE_CYCLES = 4.
// Reference model: raw levels are delayed two edges, and a channel's pressed
// state flips once the last DEBOUNCE_CYCLES delayed samples all disagree
// with it; a pulse accompanies each flip to pressed.
module tb_five_button_pulse;

   localparam int unsigned D = 4;
   localparam int unsigned W = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] raw_button = 5'b0;
   logic [4:0] button;

   int errors = 0;
   int checks = 0;

   five_button_pulse #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_button(raw_button),
      .button    (button)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [4:0] m_s1, m_s2, m_stab, m_exp;
   bit         hist [5][$];

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_stab = '0; m_exp = '0;
      for (int i = 0; i < 5; i++) hist[i].delete();
   endtask

   task automatic model_edge(input logic [4:0] raw);
      logic [4:0] lvl, s2_pre;
      bit         all_diff;
`ifdef FIVE_BUTTON_ACTIVE_LOW_EN
      lvl = ~raw;
`else
      lvl = raw;
`endif
      s2_pre = m_s2;
      m_s2   = m_s1;
      m_s1   = lvl;
      m_exp  = '0;
      for (int i = 0; i < 5; i++) begin
         hist[i].push_back(s2_pre[i]);
         if (hist[i].size() > D) void'(hist[i].pop_front());
         all_diff = (hist[i].size() == D);
         for (int j = 0; j < hist[i].size(); j++)
            if (hist[i][j] == m_stab[i]) all_diff = 0;
         if (all_diff) begin
            m_stab[i] = ~m_stab[i];
            m_exp[i]  = m_stab[i];
         end
      end
   endtask

   // Drive at the falling edge, advance one rising edge, land on falling edge.
   task automatic step(input logic [4:0] raw);
      raw_button = raw;
      @(posedge clk);
      if (rst_n) model_edge(raw);
      @(negedge clk);
   endtask

   task automatic apply_reset(input logic [4:0] raw);
      rst_n = 1'b0;
      raw_button = raw;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [4:0] exp_n;
      rst_n = 1'b0;
      raw_button = 5'b11111;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (button !== 5'b0) begin
            errors++;
            $display("FAIL reset_hold: button=%b expected=%b", button, 5'b0);
         end
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         step(5'b11111);
         exp_n = (n == D + 2) ? 5'b11111 : 5'b0;
         checks++;
         if (button !== exp_n) begin
            errors++;
            $display("FAIL reset_release edge %0d: button=%b expected=%b", n, button, exp_n);
         end
         checks++;
         if (button !== m_exp) begin
            errors++;
            $display("FAIL reset_model edge %0d: button=%b expected=%b", n, button, m_exp);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [4:0] exp_n;
      apply_reset(5'b0);
      for (int n = 1; n <= 20; n++) begin
         step(5'b00100);
         exp_n = (n == D + 2) ? 5'b00100 : 5'b0;
         checks++;
         if (button !== exp_n || button !== m_exp) begin
            errors++;
            $display("FAIL clean_press edge %0d: button=%b expected=%b model=%b",
                     n, button, exp_n, m_exp);
         end
      end
   endtask

   task automatic test_bounce();
      logic [4:0] pat [$];
      int         pulses = 0;
      apply_reset(5'b0);
      pat = {5'b1, 5'b1, 5'b1, 5'b0, 5'b1, 5'b1, 5'b1, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0, 5'b0};
      foreach (pat[k]) begin
         step(pat[k]);
         checks++;
         if (button !== 5'b0 || m_exp !== 5'b0) begin
            errors++;
            $display("FAIL bounce_reject: button=%b expected=%b", button, 5'b0);
         end
      end
      for (int n = 0; n < 10; n++) begin
         step(5'b00001);
         if (button[0]) pulses++;
         checks++;
         if (button !== m_exp) begin
            errors++;
            $display("FAIL bounce_hold: button=%b expected=%b", button, m_exp);
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL bounce_pulse_count: pulses=%0d expected=1", pulses);
      end
   endtask

   task automatic test_release_repress();
      int pulses = 0;
      apply_reset(5'b0);
      for (int n = 0; n < 30; n++) begin
         step((n < 10 || n >= 20) ? 5'b01000 : 5'b0);
         if (button[3]) pulses++;
         checks++;
         if (button !== m_exp) begin
            errors++;
            $display("FAIL release_repress edge %0d: button=%b expected=%b", n, button, m_exp);
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL repress_pulse_count: pulses=%0d expected=2", pulses);
      end
   endtask

   task automatic test_simultaneous();
      logic [4:0] seen = '0;
      apply_reset(5'b0);
      for (int n = 1; n <= 10; n++) begin
         step(5'b10101);
         seen |= button;
         checks++;
         if (button !== ((n == D + 2) ? 5'b10101 : 5'b0)) begin
            errors++;
            $display("FAIL simultaneous edge %0d: button=%b expected=%b", n, button,
                     (n == D + 2) ? 5'b10101 : 5'b0);
         end
      end
      for (int n = 1; n <= 10; n++) begin
         step(5'b10111);
         checks++;
         if (button !== ((n == D + 2) ? 5'b00010 : 5'b0)) begin
            errors++;
            $display("FAIL later_bit1 edge %0d: button=%b expected=%b", n, button,
                     (n == D + 2) ? 5'b00010 : 5'b0);
         end
      end
      checks++;
      if (seen !== 5'b10101) begin
         errors++;
         $display("FAIL simultaneous_seen: seen=%b expected=%b", seen, 5'b10101);
      end
   endtask

   task automatic test_mid_reset();
      apply_reset(5'b0);
      // Four edges with bit 3 held leaves its counter at 2.
      for (int n = 0; n < 4; n++) begin
         step(5'b01000);
         checks++;
         if (button !== 5'b0) begin
            errors++;
            $display("FAIL mid_reset_pre: button=%b expected=%b", button, 5'b0);
         end
      end
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if (button !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset_during: button=%b expected=%b", button, 5'b0);
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 10; n++) begin
         step(5'b01000);
         checks++;
         if (button !== ((n == D + 2) ? 5'b01000 : 5'b0)) begin
            errors++;
            $display("FAIL mid_reset_after edge %0d: button=%b expected=%b", n, button,
                     (n == D + 2) ? 5'b01000 : 5'b0);
         end
      end
   endtask

   task automatic test_random();
      logic [4:0] lvl = '0;
      int         hold [5];
      apply_reset(5'b0);
      for (int i = 0; i < 5; i++) hold[i] = 0;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 5; i++) begin
            if (hold[i] == 0) begin
               lvl[i]  = 1'($urandom_range(0, 1));
               hold[i] = $urandom_range(1, 9);
            end
            hold[i]--;
         end
         step(lvl);
         checks++;
         if (button !== m_exp) begin
            errors++;
            $display("FAIL random edge %0d: button=%b expected=%b", n, button, m_exp);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_repress();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
